// File: rtl/regfile_access_ctrl.sv
// Initiator for the 8x16 register file: serialises operand reads and writebacks
// from the control unit and returns the A/B operand pair through a valid/ready response.
module regfile_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  output logic [ADDR_W-1:0] Write_addr,
  output logic              Write_enable,
  output logic [DATA_W-1:0] Write_data,
  output logic [ADDR_W-1:0] ReadA_addr,
  output logic [ADDR_W-1:0] ReadB_addr,
  input  logic [DATA_W-1:0] ReadA_data,
  input  logic [DATA_W-1:0] ReadB_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ADDR,
    RD_ISSUE,
    RD_HOLD
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_a        <= '0;
      rsp_b        <= '0;
      Write_addr   <= '0;
      Write_enable <= 1'b0;
      Write_data   <= '0;
      ReadA_addr   <= '0;
      ReadB_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered, so the first cycle out of reset only arms it
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            if (req_write) begin
              Write_addr   <= req_addr_a;
              Write_data   <= req_wdata;
              Write_enable <= 1'b1;
              state        <= WR_ISSUE;
            end else begin
              ReadA_addr <= req_addr_a;
              ReadB_addr <= req_addr_b;
              state      <= RD_ADDR;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR_ISSUE: begin
          Write_enable <= 1'b0;
          req_ready    <= 1'b1;
          state        <= IDLE;
        end
        RD_ADDR: begin
          // read addresses settle into the file before the issue cycle samples it
          state <= RD_ISSUE;
        end
        RD_ISSUE: begin
          rsp_a     <= ReadA_data;
          rsp_b     <= ReadB_data;
          rsp_valid <= 1'b1;
          state     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          Write_enable <= 1'b0;
          rsp_valid    <= 1'b0;
          req_ready    <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
